// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 data mux, with a per-grant
// beat cap and a valid/ready output stream.
module mux4_rr_arbiter #(
    parameter int DW       = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] i,
    input  logic            y_ready,
    output logic [DW-1:0]   y,
    output logic            y_valid,
    output logic [3:0]      gnt,
    output logic [1:0]      sel
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

    state_t     r_state;
    logic [1:0] r_sel;
    logic [3:0] r_gnt;
    logic [1:0] r_ptr;
    logic [3:0] r_cnt;

    state_t     w_nx_state;
    logic [1:0] w_nx_sel;
    logic [3:0] w_nx_gnt;
    logic [1:0] w_nx_ptr;
    logic [3:0] w_nx_cnt;

    logic [1:0]    w_base;
    logic [1:0]    w_idx;
    logic [1:0]    w_win;
    logic          w_found;
    logic          w_valid;
    logic          w_xfer;
    logic          w_release;
    logic [DW-1:0] w_lane;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Handshake qualifiers and release detection for the current grant
    always_comb begin
        w_lane    = i[r_sel*DW +: DW];
        w_valid   = (r_state == ST_GRANT) && req[r_sel];
        w_xfer    = w_valid && y_ready;
        w_release = (r_state == ST_GRANT) &&
                    (!req[r_sel] || (w_xfer && (r_cnt == CNT_LAST)));
    end

    // Winner search; on release the just-served lane drops to the back
    always_comb begin
        w_base  = (r_state == ST_GRANT) ? (r_sel + 2'd1) : r_ptr;
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = w_base + 2'(k);
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state and next-register computation
    always_comb begin
        w_nx_state = r_state;
        w_nx_sel   = r_sel;
        w_nx_gnt   = r_gnt;
        w_nx_ptr   = r_ptr;
        w_nx_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_nx_state = ST_GRANT;
                    w_nx_sel   = w_win;
                    w_nx_gnt   = onehot(w_win);
                    w_nx_cnt   = 4'd0;
                end else begin
                    w_nx_gnt   = 4'b0000;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_nx_ptr = r_sel + 2'd1;
                    if (w_found) begin
                        w_nx_sel = w_win;
                        w_nx_gnt = onehot(w_win);
                        w_nx_cnt = 4'd0;
                    end else begin
                        w_nx_state = ST_IDLE;
                        w_nx_gnt   = 4'b0000;
                    end
                end else if (w_xfer) begin
                    w_nx_cnt = r_cnt + 4'd1;
                end else begin
                    w_nx_cnt = r_cnt;
                end
            end
            default: begin
                w_nx_state = ST_IDLE;
                w_nx_gnt   = 4'b0000;
            end
        endcase
    end

    // State and grant registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_ptr   <= 2'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nx_state;
            r_sel   <= w_nx_sel;
            r_gnt   <= w_nx_gnt;
            r_ptr   <= w_nx_ptr;
            r_cnt   <= w_nx_cnt;
        end
    end

    // Output stream: zero data whenever no valid beat is presented
    always_comb begin
        y_valid = w_valid;
        if (w_valid) begin
            y = w_lane;
        end else begin
            y = {DW{1'b0}};
        end
    end

    assign gnt = r_gnt;
    assign sel = r_sel;

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin controller that shares a 4:1 data multiplexer between four requesters and a single downstream consumer. It registers a one-hot grant and the matching 2-bit select, then steers the granted requester's data onto one output stream under a valid/ready handshake. Each grant is capped at a fixed number of beats for fairness. The block sits in front of the existing 4:1 select datapath and owns its `sel` input.

## Interface
- `DW`, default 8: data width per requester.
- `HOLD_MAX`, default 4: maximum beats transferred per grant; legal range 1..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req`  in  4: `req[n]` is high while requester n has a beat on its data lane.
- `i`  in  4*DW: packed data lanes; lane n is `i[n*DW +: DW]`.
- `y_ready`  in  1: downstream accepts a beat this cycle.
- `y`  out  DW: selected data.
- `y_valid`  out  1: `y` holds a valid beat.
- `gnt`  out  4: registered one-hot grant; all-zero when idle.
- `sel`  out  2: registered binary index of the granted lane.

## Operation
- State machine with two states:
  - IDLE: `gnt` is 0.
  - GRANT: `gnt` is one-hot and equals the decode of `sel`.
- Round-robin pointer `ptr` (2 bits) marks the highest-priority lane. Winner search runs `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, mod 4.
- IDLE, any `req` high: the winner is loaded into `sel`/`gnt`, the beat count is cleared, and the state goes to GRANT.
- GRANT:
  - `y_valid` = `req[sel]`.
  - `y` = lane `sel` when `y_valid`, else 0.
  - A transfer occurs when `y_valid && y_ready`. Each transfer increments a beat counter of width 4.
- Release conditions in GRANT, evaluated each cycle:
  - (a) `req[sel]` low. No transfer occurs that cycle.
  - (b) A transfer occurs with count == `HOLD_MAX`-1.
- On release:
  - `ptr` ← `sel`+1 (wraps 3→0).
  - Re-arbitration in the same cycle uses the updated priority order (`sel`+1 first, `sel` last), applied to the current `req` with `req[sel]` included.
  - Winner found: load the new `sel`/`gnt`, clear the count, stay in GRANT. There is no idle bubble.
  - No winner: go to IDLE, `gnt` ← 0, `sel` holds its value.
- Requester contract:
  - Hold the lane data stable while `req` is high and no transfer has occurred.
  - Dropping `req` before acceptance is legal and is treated as release (a).
- `y_ready` has no effect outside GRANT. Non-granted `req` lines never affect `y`.

## Timing
- Reset values (registers take these at the first rising edge with `rst`=1):
  - `gnt`=0, `sel`=0, `ptr`=0, count=0, state IDLE.
  - Consequently `y_valid`=0 and `y`=0.
- `rst` has priority over all other inputs. Reset mid-grant drops the grant at that edge and discards any beat not yet accepted.
- Latency: `req` rising in IDLE at cycle t gives `gnt`/`sel` valid and `y_valid` high in cycle t+1.
- Handover: a release at cycle t gives the new `gnt` at t+1. The new winner's beat can transfer at t+1.
- `y` and `y_valid` are combinational from the registered `sel` and the live `req`/`i`. `gnt` and `sel` are glitch-free registers.
- Simultaneous events:
  - `req[sel]` drops in the same cycle another requester rises: the new requester is a candidate in that cycle's arbitration.
  - HOLD_MAX expiry with only the same requester pending: that requester is re-granted immediately with count cleared.
- `y_ready` low stalls the transfer: `gnt`, `sel`, and the count are unchanged, and there is no timeout.
- The count never exceeds `HOLD_MAX`-1 in GRANT.

## Test plan
- Reset then single requester:
  - Stimulus: `rst` 2 cycles. At t0, `req`=4'b0100, `i` lane2 = 8'hA5, `y_ready`=1.
  - Response: `gnt`=4'b0100, `sel`=2, `y`=8'hA5, `y_valid`=1 at t0+1.
  - With `req` held, a 1-cycle re-grant occurs every 4 beats, with no bubble.
- Round-robin fairness:
  - Stimulus: `req`=4'b1111 constant, `y_ready`=1, `HOLD_MAX`=4.
  - Response: grant order 0,1,2,3,0, with exactly 4 consecutive transfers per grant and no idle cycles.
- Backpressure:
  - Stimulus: lane 1 granted, `y_ready`=0 for 5 cycles, then 1.
  - Response: `gnt`/`sel`/`y` held steady for those 5 cycles and the count does not advance. Transfers resume when `y_ready` returns to 1.
- Early release:
  - Stimulus: lane 3 granted, `req[3]` drops after 2 beats while `req[0]` is high.
  - Response: next cycle `gnt`=4'b0001, `sel`=0. Lane 3 is lowest priority at the next arbitration (`ptr`=0).
- Reset mid-grant:
  - Stimulus: lane 2 granted, `y_ready`=0, `rst`=1 for one cycle.
  - Response: `gnt`=0, `y_valid`=0, `sel`=0 after that edge. With `req`=4'b0101 afterwards, lane 0 is granted first.
